// File: rtl/flag_gen_pkg.sv
// rtl/flag_gen_pkg.sv - op codes, trap states and status-register flag indices for flag_gen
package flag_gen_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_PASSB  = 3'd5,
        OP_DIVCHK = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        TRAP_IDLE = 2'd0,
        TRAP_REQ  = 2'd1,
        TRAP_SERV = 2'd2
    } trap_state_e;

    localparam int FLAG_ZF   = 0;
    localparam int FLAG_SF   = 1;
    localparam int FLAG_OF   = 2;
    localparam int FLAG_UF   = 3;
    localparam int FLAG_CFFW = 4;
    localparam int FLAG_CFHL = 5;
    localparam int FLAG_CFHH = 6;
    localparam int FLAG_DF   = 7;
    localparam int FLAG_HWF  = 8;
    localparam int FLAG_SRF  = 9;
    localparam int FLAG_MVF  = 10;
    localparam int FLAG_MCF  = 11;
    localparam int FLAG_TF   = 12;
    localparam int NUM_FLAGS = 13;

    function automatic logic is_arith_op(input op_e o);
        return (o == OP_ADD) || (o == OP_SUB);
    endfunction

endpackage

// File: rtl/flag_gen_lane_add.sv
// rtl/flag_gen_lane_add.sv - H-bit adder lane with carry in/out and signed-overflow outputs
module flag_gen_lane_add #(
    parameter int H = 16
) (
    input  logic [H-1:0] a,
    input  logic [H-1:0] b,
    input  logic         cin,
    output logic [H-1:0] sum,
    output logic         cout,
    output logic         ovf_pos,
    output logic         ovf_neg
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{H{1'b0}}, cin};

    // b is already inverted for subtraction, so overflow is judged on the effective operands
    assign ovf_pos = ~a[H-1] & ~b[H-1] &  sum[H-1];
    assign ovf_neg =  a[H-1] &  b[H-1] & ~sum[H-1];

endmodule

// File: rtl/flag_gen.sv
// rtl/flag_gen.sv - ALU flag generation with sticky exceptions; trap FSM built when FLAG_GEN_TRAP_EN is defined
module flag_gen
    import flag_gen_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic         hw,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [4:0]   rs_idx,
    input  logic [4:0]   rd_idx,
    input  logic         mem_viol,
    input  logic         mem_corr,
    input  logic         clr_sticky,
    input  logic         trap_en,
    input  logic         trap_ack,
    input  logic         trap_done,
    output logic         trap_req,
    output logic [W-1:0] res,
    output logic         res_valid,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         uf,
    output logic         cffw,
    output logic         cfhl,
    output logic         cfhh,
    output logic         df,
    output logic         hwf,
    output logic         srf,
    output logic         mvf,
    output logic         mcf,
    output logic         tf
);

    localparam int H = W / 2;

    op_e            op_c;
    logic           is_sub;
    logic           is_arith;
    logic           is_div;
    logic [W-1:0]   b_eff;
    logic [H-1:0]   sum_lo;
    logic [H-1:0]   sum_hi;
    logic           cout_lo;
    logic           cout_hi;
    logic           cin_hi;
    logic           ovf_pos_hi;
    logic           ovf_neg_hi;
    logic           lo_ovf_pos_unused;
    logic           lo_ovf_neg_unused;
    logic [W-1:0]   res_d;
    logic           b_zero;
    logic           accept;
    logic           df_set;
    logic [FLAG_TF-1:0] flags_q;
    logic [FLAG_TF-1:0] flags_d;
    logic [W-1:0]   res_q;
    logic           res_valid_q;
    logic           trap_busy;
    logic [NUM_FLAGS-1:0] flags_out;

    assign op_c     = op_e'(op);
    assign is_sub   = (op_c == OP_SUB);
    assign is_arith = is_arith_op(op_c);
    assign is_div   = (op_c == OP_DIVCHK);
    assign b_eff    = is_sub ? ~b : b;

    // In half-word mode the high lane restarts with its own carry-in
    assign cin_hi = hw ? is_sub : cout_lo;

    flag_gen_lane_add #(.H(H)) u_lane_lo (
        .a       (a[H-1:0]),
        .b       (b_eff[H-1:0]),
        .cin     (is_sub),
        .sum     (sum_lo),
        .cout    (cout_lo),
        .ovf_pos (lo_ovf_pos_unused),
        .ovf_neg (lo_ovf_neg_unused)
    );

    flag_gen_lane_add #(.H(H)) u_lane_hi (
        .a       (a[W-1:H]),
        .b       (b_eff[W-1:H]),
        .cin     (cin_hi),
        .sum     (sum_hi),
        .cout    (cout_hi),
        .ovf_pos (ovf_pos_hi),
        .ovf_neg (ovf_neg_hi)
    );

    always_comb begin
        res_d = b;
        case (op_c)
            OP_ADD, OP_SUB: res_d = {sum_hi, sum_lo};
            OP_AND:         res_d = a & b;
            OP_OR:          res_d = a | b;
            OP_XOR:         res_d = a ^ b;
            OP_DIVCHK:      res_d = a;
            default:        res_d = b;
        endcase
    end

    assign b_zero = hw ? ((b[H-1:0] == '0) || (b[W-1:H] == '0)) : (b == '0);
    assign accept = in_valid & in_ready;
    assign df_set = accept & is_div & b_zero;

    always_comb begin
        flags_d = flags_q;
        if (accept) begin
            flags_d[FLAG_ZF]   = (res_d == '0);
            flags_d[FLAG_SF]   = res_d[W-1];
            flags_d[FLAG_OF]   = is_arith & ovf_pos_hi;
            flags_d[FLAG_UF]   = is_arith & ovf_neg_hi;
            flags_d[FLAG_CFFW] = is_arith & ~hw & cout_hi;
            flags_d[FLAG_CFHL] = is_arith & cout_lo;
            flags_d[FLAG_CFHH] = is_arith & cout_hi;
            flags_d[FLAG_HWF]  = hw;
            flags_d[FLAG_SRF]  = (rs_idx == rd_idx);
        end
        // Sticky: a set in the same cycle as a clear wins
        flags_d[FLAG_DF]  = df_set   | (flags_q[FLAG_DF]  & ~clr_sticky);
        flags_d[FLAG_MVF] = mem_viol | (flags_q[FLAG_MVF] & ~clr_sticky);
        flags_d[FLAG_MCF] = mem_corr | (flags_q[FLAG_MCF] & ~clr_sticky);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            res_valid_q <= accept;
            if (accept) begin
                res_q <= res_d;
            end
        end
    end

`ifdef FLAG_GEN_TRAP_EN
    trap_state_e state_q;
    trap_state_e state_d;
    logic        exc_rise;

    assign exc_rise = (df_set   & ~flags_q[FLAG_DF])
                    | (mem_viol & ~flags_q[FLAG_MVF])
                    | (mem_corr & ~flags_q[FLAG_MCF]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TRAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TRAP_IDLE: if (trap_en && exc_rise) state_d = TRAP_REQ;
            TRAP_REQ:  if (trap_ack)            state_d = TRAP_SERV;
            TRAP_SERV: if (trap_done)           state_d = TRAP_IDLE;
            default:                            state_d = TRAP_IDLE;
        endcase
    end

    assign trap_req  = (state_q == TRAP_REQ);
    assign trap_busy = (state_q != TRAP_IDLE);
    assign in_ready  = (state_q == TRAP_IDLE);
`else
    logic unused_trap_inputs;

    assign unused_trap_inputs = trap_en ^ trap_ack ^ trap_done;
    assign trap_req  = 1'b0;
    assign trap_busy = 1'b0;
    assign in_ready  = 1'b1;
`endif

    assign flags_out = {trap_busy, flags_q};

    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign zf   = flags_out[FLAG_ZF];
    assign sf   = flags_out[FLAG_SF];
    assign of   = flags_out[FLAG_OF];
    assign uf   = flags_out[FLAG_UF];
    assign cffw = flags_out[FLAG_CFFW];
    assign cfhl = flags_out[FLAG_CFHL];
    assign cfhh = flags_out[FLAG_CFHH];
    assign df   = flags_out[FLAG_DF];
    assign hwf  = flags_out[FLAG_HWF];
    assign srf  = flags_out[FLAG_SRF];
    assign mvf  = flags_out[FLAG_MVF];
    assign mcf  = flags_out[FLAG_MCF];
    assign tf   = flags_out[FLAG_TF];

endmodule

// File: tb/tb_flag_gen.sv
// tb/tb_flag_gen.sv - scoreboard bench for flag_gen; trap expectations follow FLAG_GEN_TRAP_EN
module tb_flag_gen;

`ifdef FLAG_GEN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam longint MAX32 = 64'sd2147483647;
    localparam longint MIN32 = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic        hw = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rs_idx = '0;
    logic [4:0]  rd_idx = '0;
    logic        mem_viol = 1'b0;
    logic        mem_corr = 1'b0;
    logic        clr_sticky = 1'b0;
    logic        trap_en = 1'b0;
    logic        trap_ack = 1'b0;
    logic        trap_done = 1'b0;
    logic        trap_req;
    logic [31:0] res;
    logic        res_valid;
    logic zf, sf, of, uf, cffw, cfhl, cfhh, df, hwf, srf, mvf, mcf, tf;

    flag_gen #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .hw(hw), .a(a), .b(b), .rs_idx(rs_idx), .rd_idx(rd_idx),
        .mem_viol(mem_viol), .mem_corr(mem_corr), .clr_sticky(clr_sticky),
        .trap_en(trap_en), .trap_ack(trap_ack), .trap_done(trap_done),
        .trap_req(trap_req), .res(res), .res_valid(res_valid),
        .zf(zf), .sf(sf), .of(of), .uf(uf), .cffw(cffw), .cfhl(cfhl), .cfhh(cfhh),
        .df(df), .hwf(hwf), .srf(srf), .mvf(mvf), .mcf(mcf), .tf(tf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic [8:0]  fl;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    wire [8:0]  ns_fl  = {srf, hwf, cfhh, cfhl, cffw, uf, of, sf, zf};
    wire [12:0] all_fl = {tf, mcf, mvf, srf, hwf, df, cfhh, cfhl, cffw, uf, of, sf, zf};

    // Reference model: carries from widened sums, overflow from true signed arithmetic
    function automatic exp_t model(input logic [2:0] o, input logic h, input logic [31:0] aa,
                                   input logic [31:0] bb, input logic [4:0] s, input logic [4:0] d);
        exp_t e;
        logic [31:0] r, ra, bx;
        logic [32:0] full;
        logic [16:0] lo, hi;
        longint v;
        logic sub, ar, cfw, chl, chh, ov, un;
        sub = (o == 3'd1);
        ar  = (o <= 3'd1);
        bx  = sub ? ~bb : bb;
        lo  = {1'b0, aa[15:0]} + {1'b0, bx[15:0]} + 17'(sub);
        if (h) begin
            hi  = {1'b0, aa[31:16]} + {1'b0, bx[31:16]} + 17'(sub);
            ra  = {hi[15:0], lo[15:0]};
            cfw = 1'b0;
            chl = lo[16];
            chh = hi[16];
            v   = sub ? longint'($signed(aa[31:16])) - longint'($signed(bb[31:16]))
                      : longint'($signed(aa[31:16])) + longint'($signed(bb[31:16]));
            ov  = v > 64'sd32767;
            un  = v < -64'sd32768;
        end else begin
            full = {1'b0, aa} + {1'b0, bx} + 33'(sub);
            ra   = full[31:0];
            cfw  = full[32];
            chl  = lo[16];
            chh  = full[32];
            v    = sub ? longint'($signed(aa)) - longint'($signed(bb))
                       : longint'($signed(aa)) + longint'($signed(bb));
            ov   = v > MAX32;
            un   = v < MIN32;
        end
        case (o)
            3'd0, 3'd1: r = ra;
            3'd2:       r = aa & bb;
            3'd3:       r = aa | bb;
            3'd4:       r = aa ^ bb;
            3'd6:       r = aa;
            default:    r = bb;
        endcase
        if (!ar) begin
            cfw = 1'b0; chl = 1'b0; chh = 1'b0; ov = 1'b0; un = 1'b0;
        end
        e.res = r;
        e.fl  = {s == d, h, chh, chl, cfw, un, ov, r[31], r == 32'd0};
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (sbq.size() == 0) begin
                check("spurious_res_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("res", res, mon_e.res);
                check("flags", {23'd0, ns_fl}, {23'd0, mon_e.fl});
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic h, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [4:0] s, input logic [4:0] d);
        @(negedge clk);
        op = o; hw = h; a = aa; b = bb; rs_idx = s; rd_idx = d;
        in_valid = 1'b1;
        if (in_ready) sbq.push_back(model(o, h, aa, bb, s, d));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: mem_viol = 1'b1;
            1: mem_corr = 1'b1;
            2: clr_sticky = 1'b1;
            3: trap_ack = 1'b1;
            default: trap_done = 1'b1;
        endcase
        @(negedge clk);
        mem_viol = 1'b0; mem_corr = 1'b0; clr_sticky = 1'b0; trap_ack = 1'b0; trap_done = 1'b0;
    endtask

    task automatic directed_add();
        send(3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd1, 5'd2);
        @(negedge clk);
        check("add_res", res, 32'h8000_0000);
        check("add_flags", {23'd0, ns_fl}, 32'h026);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_flags", {19'd0, all_fl}, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_trap_req", {31'd0, trap_req}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        directed_add();
        send(3'd1, 1'b0, 32'd5, 32'd5, 5'd3, 5'd4);
        @(negedge clk);
        check("sub_flags", {23'd0, ns_fl}, 32'h071);
        send(3'd0, 1'b1, 32'hFFFF_0001, 32'h0001_FFFF, 5'd7, 5'd7);
        @(negedge clk);
        check("hw_add_res", res, 32'd0);
        check("hw_add_flags", {23'd0, ns_fl}, 32'h1E1);

        // Half-word DIVCHK with only the low divisor lane zero
        send(3'd6, 1'b1, 32'h1234_5678, 32'h0001_0000, 5'd0, 5'd1);
        @(negedge clk);
        check("hw_div_df", {31'd0, df}, 32'd1);
        check("hw_div_trap_off", {31'd0, trap_req}, 32'd0);
        pulse(2);
        check("df_cleared", {31'd0, df}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            rb = (i % 7 == 0) ? 32'h7FFF_FFFF : $urandom;
            send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        @(negedge clk);
        pulse(2);

        trap_en = 1'b1;
        send(3'd6, 1'b0, 32'h0000_1234, 32'd0, 5'd1, 5'd1);
        @(negedge clk);
        check("div_df", {31'd0, df}, 32'd1);
        check("div_trap_req", {31'd0, trap_req}, {31'd0, TRAP});
        check("div_in_ready", {31'd0, in_ready}, {31'd0, !TRAP});
        check("div_tf", {31'd0, tf}, {31'd0, TRAP});
        send(3'd0, 1'b0, 32'd1, 32'd2, 5'd1, 5'd2);
        pulse(3);
        check("ack_trap_req", {31'd0, trap_req}, 32'd0);
        check("ack_tf", {31'd0, tf}, {31'd0, TRAP});
        check("ack_in_ready", {31'd0, in_ready}, {31'd0, !TRAP});
        pulse(4);
        check("done_in_ready", {31'd0, in_ready}, 32'd1);
        check("done_tf", {31'd0, tf}, 32'd0);

        pulse(0);
        check("viol_mvf", {31'd0, mvf}, 32'd1);
        check("viol_trap_req", {31'd0, trap_req}, {31'd0, TRAP});
        pulse(3);
        pulse(1);
        check("serv_mcf", {31'd0, mcf}, 32'd1);
        check("serv_no_retrig", {31'd0, trap_req}, 32'd0);
        check("serv_tf", {31'd0, tf}, {31'd0, TRAP});
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_flags", {19'd0, all_fl}, 32'd0);
        check("midrst_res", res, 32'd0);
        check("midrst_trap_req", {31'd0, trap_req}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        trap_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        directed_add();

        pulse(0);
        check("mvf_set", {31'd0, mvf}, 32'd1);
        @(negedge clk);
        mem_viol = 1'b1; clr_sticky = 1'b1;
        @(negedge clk);
        mem_viol = 1'b0;
        check("mvf_set_wins", {31'd0, mvf}, 32'd1);
        @(negedge clk);
        clr_sticky = 1'b0;
        check("mvf_clr", {31'd0, mvf}, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flag_gen.md
# flag_gen

Flag generation stage that sits directly upstream of the status register bank. Each cycle it accepts one ALU operation and its operands, and computes the 13 condition and exception flags from them. The flags are registered and drive the status register's flag inputs one-to-one. It also makes the exception flags sticky and runs a small trap handshake FSM that stalls the issuing pipeline while a trap is serviced.

## Interface
- W, 32: operand/result width; even, ≥4; half width H = W/2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation present this cycle
- in_ready  out  1  stage can accept; an op transfers when in_valid & in_ready
- op  in  3  operation code (see package)
- hw  in  1  half-word mode: two independent H-bit lanes
- a, b  in  W  operands
- rs_idx, rd_idx  in  5  source/destination register indices
- mem_viol, mem_corr  in  1  memory-unit violation/corruption pulses, sampled every cycle
- clr_sticky  in  1  clear df/mvf/mcf
- trap_en  in  1  traps enabled
- trap_ack, trap_done  in  1  trap controller handshake
- trap_req  out  1  trap request
- res  out  W  registered result
- res_valid  out  1  one-cycle pulse per accepted op
- zf, sf, of, uf, cffw, cfhl, cfhh, df, hwf, srf, mvf, mcf, tf  out  1 each  flags to the status register

## Operation
- Ops: ADD, SUB, AND, OR, XOR, PASSB, DIVCHK.
- SUB computes a + ~b + 1. Carry is the adder carry-out, so carry=1 means no borrow.
- Full-word mode (hw=0):
  - cffw = carry out of bit W-1.
  - cfhl = carry into bit H.
  - cfhh = cffw.
- Half-word mode (hw=1):
  - The lanes are independent; no carry propagates from bit H-1 to bit H.
  - cfhl = low-lane carry out; cfhh = high-lane carry out; cffw = 0.
  - of/uf/sf are taken from the high lane.
- zf = (res == 0).
- sf = res MSB.
- Signed overflow flags (ADD/SUB only): of = overflow toward positive limit (operands effectively non-negative, result negative); uf = overflow toward negative limit.
- Logic ops and PASSB: of = uf = 0 and all three carry flags = 0.
- DIVCHK: res = a; df set when b == 0 (in hw mode, when either lane of b is 0).
- hwf = registered hw. srf = (rs_idx == rd_idx).
- Non-sticky flags update only on an accepted op and hold otherwise.
- Sticky flags:
  - df is set by DIVCHK with a zero divisor.
  - mvf/mcf are set by mem_viol/mem_corr in any cycle, independent of in_valid.
  - All three hold until clr_sticky. If set and clear occur in the same cycle, set wins.
- Trap FSM (states IDLE, REQ, SERV):
  - IDLE→REQ when trap_en and any of df/mvf/mcf makes a 0→1 transition this cycle.
  - REQ→SERV on trap_ack.
  - SERV→IDLE on trap_done.
  - trap_req = (state == REQ). tf = (state != IDLE). in_ready = (state == IDLE).
  - Exceptions arriving in REQ/SERV still set their flags but do not re-trigger.
  - trap_ack in IDLE/SERV and trap_done in IDLE/REQ are ignored.

## Timing
- Latency 1: flags, res and res_valid are registered in the cycle after acceptance.
- An exception seen in cycle N sets the flag at edge N+1. The FSM enters REQ at that same edge, so in_ready drops in cycle N+1.
- trap_ack sampled in cycle M gives SERV at M+1. trap_done sampled in cycle K gives IDLE, with in_ready=1, at K+1.
- Reset (asynchronous, any state, including mid-trap): all flags 0, res 0, res_valid 0, trap_req 0, state IDLE, in_ready 1.

## Configuration
- FLAG_GEN_TRAP_EN defined: trap FSM present as above.
- Not defined:
  - No FSM; trap_req = 0, tf = 0, in_ready = 1 constantly.
  - trap_en, trap_ack and trap_done are unused.
  - Sticky flags behave identically.

## Structure
- Package flag_gen_pkg:
  - op code enum (ADD=0, SUB=1, AND=2, OR=3, XOR=4, PASSB=5, DIVCHK=6; 7 reserved, treated as PASSB).
  - trap state enum.
  - flag index constants 0–12 in status-register order zf…tf.
- One sub-module, flag_gen_lane_add: H-bit adder lane with carry-in/out and signed-overflow outputs, instantiated twice; the lane carry is chained only when hw = 0.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → res 0x80000000; of=1, sf=1, uf=0, zf=0, cffw=0, cfhl=1.
- SUB a=5, b=5 → res 0; zf=1, cffw=1, of=uf=0.
- hw=1 ADD a=0xFFFF0001, b=0x0001FFFF → res 0x00000000; cfhl=1, cfhh=1, cffw=0, zf=1, hwf=1.
- DIVCHK b=0 with trap_en=1 → df=1 and trap_req=1 next cycle, in_ready=0. trap_ack → tf stays 1, trap_req=0. trap_done → in_ready=1 next cycle.
- mvf already set; mem_viol=1 and clr_sticky=1 in the same cycle → mvf stays 1. Next cycle clr_sticky alone → mvf=0.
- Assert rst_n low during SERV → all outputs 0 immediately, in_ready=1. Replay the ADD scenario after reset → same results.
